dmem_write_checker: RTL
=======================

DMEM_WRITE_CHECKER -- requirements
Module: dmem_write_checker

Interface
REQ-001 Parameter AW, 32, address width of the monitored data-memory write port.
REQ-002 Parameter DW, 32, data width of the monitored write port.
REQ-003 Parameter N_ALLOW, 4, number of allowed-address table entries (1..8).
REQ-004 Parameter TRACE_DEPTH, 8, trace FIFO depth (power of two, 2..64).
REQ-005 Parameter TIMEOUT, 1000, RUN-state cycle limit; 0 disables the timeout.
REQ-006 Parameter CW, 16, width of the write counter.
REQ-007 clk  in  1  system clock, rising-edge active.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 arm  in  1  single-cycle pulse: clear counters and trace, enter RUN.
REQ-010 clear  in  1  single-cycle pulse: return to IDLE from any state.
REQ-011 mem_we  in  1  monitored write enable.
REQ-012 mem_addr  in  AW  monitored write address.
REQ-013 mem_wdata  in  DW  monitored write data.
REQ-014 pass_addr, pass_data  in  AW, DW  success address/data pair; held stable while armed.
REQ-015 cfg_we  in  1  allow-table write strobe.
REQ-016 cfg_idx  in  clog2(N_ALLOW)  table entry index.
REQ-017 cfg_addr, cfg_mask, cfg_en  in  AW, AW, 1  entry base address, compare mask, entry enable.
REQ-018 state  out  3  encoded state (IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4).
REQ-019 done  out  1  high in PASS, FAIL or TIMEOUT.
REQ-020 wr_count  out  CW  writes observed since arm, saturating.
REQ-021 fail_addr, fail_data  out  AW, DW  capture of the offending write.
REQ-022 trace_valid  out  1; trace_ready  in  1; trace_addr  out  AW; trace_data  out  DW  trace pop handshake.
REQ-023 trace_overflow  out  1  sticky: trace entry dropped since arm.

Function
REQ-024 IDLE: arm -> RUN; mem_we is ignored; cfg writes are accepted in every state and take effect on the next cycle.
REQ-025 RUN, write with (mem_addr==pass_addr && mem_wdata==pass_data) -> PASS; this check has priority over the allow table.
REQ-026 RUN, write where some enabled entry i has (mem_addr & mask_i)==(addr_i & mask_i) -> stay in RUN.
REQ-027 RUN, write matching neither condition -> FAIL; fail_addr/fail_data capture that write in the same edge.
REQ-028 RUN, cycle counter reaches TIMEOUT without a terminating write -> TIMEOUT; a write on the expiry cycle is evaluated first and wins.
REQ-029 Every write sampled in RUN, including the terminating one, increments wr_count (saturating at 2^CW-1) and pushes {addr,data} into the trace.
REQ-030 All outputs are registered: state/done/wr_count/fail_* update one cycle after the sampling edge.
REQ-031 arm in RUN or a terminal state restarts RUN: wr_count, cycle counter, trace, overflow and fail_* clear; arm together with mem_we drops that write.
REQ-032 clear has priority over arm and writes; terminal states are held until clear or arm.
REQ-033 Trace: trace_valid is high when non-empty; a pop occurs on trace_valid && trace_ready; output is the oldest entry (show-ahead).
REQ-034 Trace full with push and no pop -> oldest entry dropped, new entry stored, trace_overflow set.
REQ-035 Trace full with simultaneous push and pop -> pop oldest, store new, no overflow; empty with push and pop -> push only, no pop.
REQ-036 Pops remain permitted in IDLE and terminal states.

Reset
REQ-037 reset low: state=IDLE, done=0, wr_count=0, fail_*=0, trace empty, trace_valid=0, trace_overflow=0, allow table all disabled; release is synchronised to clk internally.

Structure
REQ-038 The state encoding and default parameter values belong in shared package mcu_dbg_pkg.
REQ-039 The trace buffer is the sub-module trace_fifo (overwrite-on-full, show-ahead); the table match logic stays inline.

Verification
REQ-040 Entry0=96/mask all-ones; arm; write 96=5, then 100=7 -> PASS, wr_count=2, done=1, trace pops (96,5),(100,7).
REQ-041 Entry0=96; arm; write 104=3 -> FAIL, fail_addr=104, fail_data=3, wr_count=1.
REQ-042 TIMEOUT=50; arm; no writes -> state=TIMEOUT after 50 cycles; rerun with write 100=7 on cycle 50 -> PASS.
REQ-043 Entry0=0x0/mask 0xFFFFFF00, TRACE_DEPTH=8; arm; 10 writes to 0x00..0x24, no pops -> RUN, overflow=1, pops return writes 3..10.
REQ-044 Assert reset mid-RUN after 3 writes -> all outputs at reset values immediately, table disabled; a subsequent arm and write 96 -> FAIL.
REQ-045 In PASS, pulse arm and clear on the same cycle -> IDLE, counters unchanged.

Source files
------------

// File: rtl/mcu_dbg_pkg.sv
// Shared definitions for the MCU debug/monitor blocks.
// Holds the checker state encoding and the default parameter values.
// No ports: this is a package imported by the checker and its bench.
package mcu_dbg_pkg;

  // Checker state encoding, visible on the 3-bit state output.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } chk_state_e;

  localparam int unsigned DEF_AW          = 32;
  localparam int unsigned DEF_DW          = 32;
  localparam int unsigned DEF_N_ALLOW     = 4;
  localparam int unsigned DEF_TRACE_DEPTH = 8;
  localparam int unsigned DEF_TIMEOUT     = 1000;
  localparam int unsigned DEF_CW          = 16;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead trace FIFO that overwrites its oldest entry when full.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          empties the FIFO and clears the overflow flag
//   push/push_data write one entry (never refused)
//   pop_ready      consumer ready; a pop happens on valid && pop_ready
//   valid/head     non-empty flag and oldest entry
//   overflow       sticky: an entry was dropped since the last flush/reset
//
// Handshake: head is presented whenever valid is high; the entry is consumed
// on the rising edge where valid && pop_ready. push has no back-pressure.
module trace_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         overflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         pop;
  logic         drop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign valid = !empty;
  assign pop   = valid && pop_ready;
  // Full with push and no pop: advance the read side to discard the oldest.
  assign drop  = push && full && !pop;
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)        wr_ptr   <= wr_ptr + 1'b1;
      if (pop || drop) rd_ptr   <= rd_ptr + 1'b1;
      if (drop)        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dmem_write_checker.sv
// Data-memory write checker: after arm, every write on the monitored port is
// classified. The success pair ends the run in PASS, a write inside an enabled
// allow-table window keeps it in RUN, anything else ends it in FAIL with the
// write captured. A cycle limit ends a quiet run in TIMEOUT. All writes
// sampled in RUN are counted and logged to a trace FIFO.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   arm, clear                     start/restart a run, return to IDLE
//   mem_we/mem_addr/mem_wdata      monitored write port
//   pass_addr/pass_data            success write
//   cfg_we/cfg_idx/cfg_addr/cfg_mask/cfg_en   allow-table programming
//   state, done                    encoded state (debug), terminal flag
//   wr_count                       saturating write count since arm
//   fail_addr/fail_data            offending write
//   trace_valid/trace_ready/trace_addr/trace_data   trace pop handshake
//   trace_overflow                 sticky trace drop flag
module dmem_write_checker
  import mcu_dbg_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned N_ALLOW     = DEF_N_ALLOW,
  parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned CW          = DEF_CW,
  localparam int unsigned IW         = (N_ALLOW > 1) ? $clog2(N_ALLOW) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          clear,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [AW-1:0] pass_addr,
  input  logic [DW-1:0] pass_data,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_addr,
  input  logic [AW-1:0] cfg_mask,
  input  logic          cfg_en,
  output logic [2:0]    state,
  output logic          done,
  output logic [CW-1:0] wr_count,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [AW-1:0] trace_addr,
  output logic [DW-1:0] trace_data,
  output logic          trace_overflow
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

  // Reset: asserts asynchronously, releases two clk edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Allow table. Only the enables need a reset value.
  logic [AW-1:0]      tbl_addr [N_ALLOW];
  logic [AW-1:0]      tbl_mask [N_ALLOW];
  logic [N_ALLOW-1:0] tbl_en;
  logic               cfg_ok;

  assign cfg_ok = cfg_we && (32'(cfg_idx) < N_ALLOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tbl_en <= '0;
    else if (cfg_ok) tbl_en[cfg_idx] <= cfg_en;
  end

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_mask[cfg_idx] <= cfg_mask;
    end
  end

  logic allow_hit;
  logic pass_hit;

  always_comb begin
    allow_hit = 1'b0;
    for (int i = 0; i < N_ALLOW; i++) begin
      if (tbl_en[i] && ((mem_addr & tbl_mask[i]) == (tbl_addr[i] & tbl_mask[i])))
        allow_hit = 1'b1;
    end
  end

  assign pass_hit = (mem_addr == pass_addr) && (mem_wdata == pass_data);

  // Checker FSM
  chk_state_e    st_q;
  logic [TW-1:0] cyc_q;
  logic [TW-1:0] cyc_inc;
  logic          timeout_hit;
  logic          sample_wr;
  logic          flush;

  assign cyc_inc     = cyc_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cyc_inc == TO_VAL);
  // A write is taken only in RUN and only when no control pulse overrides it.
  assign sample_wr   = (st_q == ST_RUN) && mem_we && !arm && !clear;
  assign flush       = arm && !clear;
  assign state       = st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      done      <= 1'b0;
      wr_count  <= '0;
      cyc_q     <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (clear) begin
      st_q <= ST_IDLE;
      done <= 1'b0;
    end else if (arm) begin
      st_q      <= ST_RUN;
      done      <= 1'b0;
      wr_count  <= '0;
      cyc_q     <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (st_q == ST_RUN) begin
      cyc_q <= cyc_inc;
      if (mem_we) begin
        if (wr_count != '1) wr_count <= wr_count + 1'b1;
        // The write on the expiry cycle is classified before the timeout.
        if (pass_hit) begin
          st_q <= ST_PASS;
          done <= 1'b1;
        end else if (!allow_hit) begin
          st_q      <= ST_FAIL;
          done      <= 1'b1;
          fail_addr <= mem_addr;
          fail_data <= mem_wdata;
        end else if (timeout_hit) begin
          st_q <= ST_TIMEOUT;
          done <= 1'b1;
        end
      end else if (timeout_hit) begin
        st_q <= ST_TIMEOUT;
        done <= 1'b1;
      end
    end
  end

  // Trace buffer
  logic [AW+DW-1:0] trace_head;

  trace_fifo #(
    .W     (AW + DW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (sample_wr),
    .push_data ({mem_addr, mem_wdata}),
    .pop_ready (trace_ready),
    .valid     (trace_valid),
    .head      (trace_head),
    .overflow  (trace_overflow)
  );

  assign trace_addr = trace_head[AW+DW-1:DW];
  assign trace_data = trace_head[DW-1:0];

endmodule
